// File: rtl/mux_8_1_sweep_ctrl.sv
// Sweep sequencer for an 8:1 fabric mux: drives a latched pattern on D0..D7,
// steps the select 0..7 with a settle window each, and scores the synchronized mux output.
module mux_8_1_sweep_ctrl #(
  parameter int SETTLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       clock0,
  input  logic       global_resetn,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] pattern_i,
  input  logic       mux_out_i,
  output logic [7:0] d_o,
  output logic [2:0] s_o,
  output logic       busy,
  output logic       done,
  output logic [3:0] pass_cnt,
  output logic [3:0] fail_cnt,
  output logic [7:0] fail_mask,
  output logic       all_pass
);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t                 state, state_n;
  logic [3:0]             cnt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   sample;
  logic                   match;

  assign sample = sync[SYNC_STAGES-1];
  assign match  = (sample == d_o[s_o]);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start && !abort) state_n = SETTLE;
      SETTLE:  if (abort) state_n = IDLE;
               else if (cnt == CNT_LAST) state_n = CHECK;
      CHECK:   if (abort) state_n = IDLE;
               else if (s_o == 3'd7) state_n = DONE;
               else state_n = SETTLE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock0 or negedge global_resetn) begin
    if (!global_resetn) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= (state_n != IDLE);
      done  <= (state_n == DONE);
    end
  end

  // mux_out_i is asynchronous to clock0; only the last stage is ever compared.
  always_ff @(posedge clock0 or negedge global_resetn) begin
    if (!global_resetn) begin
      sync <= '0;
    end else begin
      sync[0] <= mux_out_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
    end
  end

  always_ff @(posedge clock0 or negedge global_resetn) begin
    if (!global_resetn) begin
      d_o       <= '0;
      s_o       <= '0;
      cnt       <= '0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      fail_mask <= '0;
      all_pass  <= 1'b0;
    end else if (state != IDLE && abort) begin
      // Partial counts stay visible for debug; the sweep is not reported as passing.
      s_o      <= '0;
      all_pass <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start && !abort) begin
          d_o       <= pattern_i;
          s_o       <= '0;
          cnt       <= '0;
          pass_cnt  <= '0;
          fail_cnt  <= '0;
          fail_mask <= '0;
          all_pass  <= 1'b0;
        end
        SETTLE: cnt <= cnt + 4'd1;
        CHECK: begin
          if (match) begin
            pass_cnt <= pass_cnt + 4'd1;
          end else begin
            fail_cnt       <= fail_cnt + 4'd1;
            fail_mask[s_o] <= 1'b1;
          end
          if (s_o != 3'd7) begin
            s_o <= s_o + 3'd1;
            cnt <= '0;
          end
        end
        DONE: all_pass <= (fail_cnt == 4'd0);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_8_1_sweep_ctrl.sv
// Bench for mux_8_1_sweep_ctrl: two instances (default and SETTLE_CYCLES=3) driven by
// behavioural mux models with configurable delay; sweep results scored through a queue.
module tb_mux_8_1_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, start, abort;
  logic [7:0] pattern;
  logic       mux_a, mux_b;
  logic [7:0] d_a, d_b, fm_a, fm_b;
  logic [2:0] s_a, s_b;
  logic       busy_a, busy_b, done_a, done_b, ap_a, ap_b;
  logic [3:0] pc_a, pc_b, fc_a, fc_b;

  logic       tie0, fen;
  logic [2:0] fsel;
  int         kb;
  logic       dla;
  logic [3:0] dlb;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mux_8_1_sweep_ctrl u_a (
    .clock0(clk), .global_resetn(rst_n), .start(start), .abort(abort),
    .pattern_i(pattern), .mux_out_i(mux_a), .d_o(d_a), .s_o(s_a),
    .busy(busy_a), .done(done_a), .pass_cnt(pc_a), .fail_cnt(fc_a),
    .fail_mask(fm_a), .all_pass(ap_a));

  mux_8_1_sweep_ctrl #(.SETTLE_CYCLES(3), .SYNC_STAGES(2)) u_b (
    .clock0(clk), .global_resetn(rst_n), .start(start), .abort(abort),
    .pattern_i(pattern), .mux_out_i(mux_b), .d_o(d_b), .s_o(s_b),
    .busy(busy_b), .done(done_b), .pass_cnt(pc_b), .fail_cnt(fc_b),
    .fail_mask(fm_b), .all_pass(ap_b));

  // Fabric models: out follows D[sel] after a register delay; A can be tied low or forced high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dla <= 1'b0;
      dlb <= '0;
    end else begin
      dla <= d_a[s_a];
      dlb <= {dlb[2:0], d_b[s_b]};
    end
  end

  always_comb begin
    mux_a = dla;
    if (tie0) mux_a = 1'b0;
    else if (fen && s_a == fsel) mux_a = 1'b1;
    mux_b = (kb == 0) ? d_b[s_b] : dlb[kb-1];
  end

  typedef struct packed {
    logic [3:0] pass;
    logic [3:0] fail;
    logic [7:0] mask;
    logic       ap;
    logic [7:0] lat;
  } exp_t;

  typedef struct packed {
    logic [7:0] pat;
    logic       tie0;
    logic       fen;
    logic [2:0] fsel;
    exp_t       e;
  } vec_t;

  exp_t sb[$];
  vec_t vt[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One sweep; start pulses re-issued at cycles r1/r2 (when >= 0) must be ignored.
  task automatic sweep(input bit on_b, input logic [7:0] pat, input exp_t e,
                       input int r1, input int r2);
    exp_t got_e;
    int   n, busy_n, bad_s, per;
    bit   got;
    per = on_b ? 4 : 5;
    sb.push_back(e);
    @(negedge clk);
    pattern = pat;
    start   = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    n      = 0;
    got    = 1'b0;
    busy_n = 0;
    bad_s  = 0;
    while (!got && n < 200) begin
      start = (n == r1) || (n == r2);
      if (on_b ? busy_b : busy_a) busy_n++;
      if (on_b ? done_b : done_a) begin
        got = 1'b1;
      end else begin
        if (32'(on_b ? s_b : s_a) != 32'(n / per)) bad_s++;
        @(negedge clk);
        n++;
      end
    end
    start = 1'b0;
    got_e = sb.pop_front();
    chk("done_seen", 32'(got), 32'd1);
    chk("done_latency", n, 32'(got_e.lat));
    chk("sel_steps", bad_s, 0);
    chk("pass_cnt", on_b ? pc_b : pc_a, got_e.pass);
    chk("fail_cnt", on_b ? fc_b : fc_a, got_e.fail);
    chk("fail_mask", on_b ? fm_b : fm_a, got_e.mask);
    @(negedge clk);
    chk("busy_len", busy_n, 32'(got_e.lat) + 1);
    chk("busy_clear", on_b ? busy_b : busy_a, 1'b0);
    chk("all_pass", on_b ? ap_b : ap_a, got_e.ap);
    chk("done_one_cycle", on_b ? done_b : done_a, 1'b0);
  endtask

  initial begin
    int   seen;
    exp_t e;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; pattern = 8'h00;
    tie0 = 1'b0; fen = 1'b0; fsel = 3'd0; kb = 1;

    vt[0] = '{8'h55, 1'b0, 1'b0, 3'd0, '{4'd8, 4'd0, 8'h00, 1'b1, 8'd40}};
    vt[1] = '{8'h55, 1'b0, 1'b1, 3'd5, '{4'd7, 4'd1, 8'h20, 1'b0, 8'd40}};
    vt[2] = '{8'hFF, 1'b1, 1'b0, 3'd0, '{4'd0, 4'd8, 8'hFF, 1'b0, 8'd40}};
    vt[3] = '{8'hA5, 1'b0, 1'b0, 3'd0, '{4'd8, 4'd0, 8'h00, 1'b1, 8'd40}};
    vt[4] = '{8'h00, 1'b0, 1'b1, 3'd5, '{4'd7, 4'd1, 8'h20, 1'b0, 8'd40}};
    vt[5] = '{8'h3C, 1'b1, 1'b0, 3'd0, '{4'd4, 4'd4, 8'h3C, 1'b0, 8'd40}};
    vt[6] = '{8'hFF, 1'b0, 1'b1, 3'd5, '{4'd8, 4'd0, 8'h00, 1'b1, 8'd40}};

    repeat (3) @(negedge clk);
    chk("reset_state", {d_a, s_a, busy_a, done_a, pc_a, fc_a, fm_a, ap_a}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vt[i]) begin
      tie0 = vt[i].tie0;
      fen  = vt[i].fen;
      fsel = vt[i].fsel;
      sweep(1'b0, vt[i].pat, vt[i].e, -1, -1);
    end
    tie0 = 1'b0; fen = 1'b0;

    // Re-pulsed start mid-sweep must not disturb timing or results.
    sweep(1'b0, 8'h55, '{4'd8, 4'd0, 8'h00, 1'b1, 8'd40}, 3, 20);

    // start and abort together in IDLE: abort wins.
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", busy_a, 1'b0);
    repeat (3) @(negedge clk);

    // Abort at cycle 17 (select 3): three selects already scored.
    pattern = 8'h55; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (17) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy_a, 1'b0);
    chk("abort_sel", s_a, 3'd0);
    chk("abort_pass_cnt", pc_a, 4'd3);
    chk("abort_fail_cnt", fc_a, 4'd0);
    chk("abort_all_pass", ap_a, 1'b0);
    seen = 0;
    repeat (30) begin
      if (done_a) seen++;
      @(negedge clk);
    end
    chk("abort_no_done", seen, 0);

    // Asynchronous reset at cycle 9 of a sweep clears everything before the next edge.
    pattern = 8'h3C; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset_async_a", {d_a, s_a, busy_a, done_a, pc_a, fc_a, fm_a, ap_a}, 32'd0);
    chk("reset_async_b", {d_b, s_b, busy_b, done_b, pc_b, fc_b, fm_b, ap_b}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // SETTLE_CYCLES=3: a 3-register fabric delay sees the previous select's value.
    kb = 3;
    e  = '{4'd4, 4'd4, 8'hAA, 1'b0, 8'd32};
    sweep(1'b1, 8'h66, e, -1, -1);
    repeat (12) @(negedge clk);
    kb = 1;
    e  = '{4'd8, 4'd0, 8'h00, 1'b1, 8'd32};
    sweep(1'b1, 8'h66, e, -1, -1);
    repeat (12) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
